// File: rtl/pipe_if_fetch.sv
// pipe_if_fetch: instruction-fetch control stage.
//
// Fetches the current pc from instruction memory over a req/ack handshake,
// drives the write side of the external PC register (npc/wpc), and loads the
// IF/ID register. A one-entry skid buffer absorbs a fetch that completes while
// decode is stalled; branch redirects squash IF/ID and the skid.
//
// Ports:
//   clk, clrn                 clock (rising edge), synchronous active-low reset
//   pc                        current PC read back from the PC register
//   npc, wpc                  next PC and its write enable (combinational)
//   imem_req/addr/ack/rdata   instruction memory handshake
//   br_taken, br_target       redirect request from a later stage
//   id_stall                  decode cannot accept IF/ID this cycle
//   id_valid, id_inst, id_pc4 IF/ID register contents
module pipe_if_fetch #(
    parameter int unsigned  W        = 32,
    parameter int unsigned  PC_STEP  = 4,
    parameter logic [W-1:0] NOP_INST = '0
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] pc,
    output logic [W-1:0] npc,
    output logic         wpc,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    input  logic         br_taken,
    input  logic [W-1:0] br_target,
    input  logic         id_stall,
    output logic         id_valid,
    output logic [W-1:0] id_inst,
    output logic [W-1:0] id_pc4
);

    typedef enum logic [1:0] {StReq, StHold, StDrop} state_e;

    localparam logic [W-1:0] Step = W'(PC_STEP);

    state_e       state_q;
    logic         id_valid_q;
    logic [W-1:0] id_inst_q;
    logic [W-1:0] id_pc4_q;
    logic [W-1:0] skid_inst_q;
    logic [W-1:0] skid_pc4_q;
    logic [W-1:0] tgt_q;

    logic [W-1:0] pc4;
    logic         if_free;

    assign pc4       = pc + Step;  // wraps modulo 2^W
    assign imem_addr = pc;
    // IF/ID can take a new instruction if empty or drained this cycle.
    assign if_free   = !id_valid_q || !id_stall;

    assign id_valid = id_valid_q;
    assign id_inst  = id_inst_q;
    assign id_pc4   = id_pc4_q;

    always_comb begin
        imem_req = 1'b0;
        wpc      = 1'b0;
        npc      = '0;
        if (clrn) begin
            unique case (state_q)
                StReq: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        wpc = 1'b1;
                        npc = br_taken ? br_target : pc4;
                    end
                end
                StDrop: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        wpc = 1'b1;
                        // A redirect arriving with the ack is newer than the saved one.
                        npc = br_taken ? br_target : tgt_q;
                    end
                end
                StHold: begin
                    if (br_taken) begin
                        wpc = 1'b1;
                        npc = br_target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= StReq;
            id_valid_q  <= 1'b0;
            id_inst_q   <= NOP_INST;
            id_pc4_q    <= '0;
            skid_inst_q <= NOP_INST;
            skid_pc4_q  <= '0;
            tgt_q       <= '0;
        end else begin
            if (id_valid_q && !id_stall) begin
                id_valid_q <= 1'b0;
            end
            unique case (state_q)
                StReq: begin
                    if (imem_ack) begin
                        if (!br_taken) begin
                            if (if_free) begin
                                id_inst_q  <= imem_rdata;
                                id_pc4_q   <= pc4;
                                id_valid_q <= 1'b1;
                            end else begin
                                skid_inst_q <= imem_rdata;
                                skid_pc4_q  <= pc4;
                                state_q     <= StHold;
                            end
                        end
                    end else if (br_taken) begin
                        // Fetch still in flight: remember where to go once it lands.
                        tgt_q   <= br_target;
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (br_taken) begin
                        tgt_q <= br_target;
                    end
                    if (imem_ack) begin
                        state_q <= StReq;
                    end
                end
                StHold: begin
                    if (br_taken) begin
                        state_q <= StReq;
                    end else if (!id_stall) begin
                        id_inst_q  <= skid_inst_q;
                        id_pc4_q   <= skid_pc4_q;
                        id_valid_q <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
            // Squash wins over any load issued above.
            if (br_taken) begin
                id_valid_q  <= 1'b0;
                id_inst_q   <= NOP_INST;
                skid_inst_q <= NOP_INST;
                skid_pc4_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Bench for pipe_if_fetch: directed scenarios followed by randomized traffic,
// all checked against a queue-based model of the fetch buffer (IF/ID plus
// skid seen as a FIFO of depth two) and a model of the external PC register.
module tb_pipe_if_fetch;

    localparam logic [31:0] Nop = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] npc;
    logic        wpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;

    always #5 clk = ~clk;

    pipe_if_fetch #(
        .W       (32),
        .PC_STEP (4),
        .NOP_INST(Nop)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .pc        (pc_reg),
        .npc       (npc),
        .wpc       (wpc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .id_stall  (id_stall),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc4    (id_pc4)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: buffered instructions in arrival order (front = IF/ID).
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    ent_t        fq[$];
    bit          mdl_init  = 1'b0;
    bit          drop_m    = 1'b0;   // outstanding fetch must be thrown away
    logic [31:0] drop_t    = 32'h0;
    logic [31:0] disp_inst = Nop;
    logic [31:0] disp_pc4  = 32'h0;

    task automatic cycle(input bit rst_n, input bit a, input bit b, input logic [31:0] bt,
                         input bit st);
        bit          e_req;
        bit          e_wpc;
        logic [31:0] e_npc;
        bit          holding;
        ent_t        e;
        @(negedge clk);
        holding    = (fq.size() == 2);
        e_req      = rst_n && !holding;
        clrn       = rst_n;
        br_taken   = b;
        br_target  = bt;
        id_stall   = st;
        imem_ack   = a && e_req;
        imem_rdata = pc_reg ^ 32'hA5A5_A5A5;
        e_wpc      = 1'b0;
        e_npc      = 32'h0;
        if (rst_n) begin
            if (holding) begin
                e_wpc = b;
                e_npc = bt;
            end else if (imem_ack) begin
                e_wpc = 1'b1;
                e_npc = b ? bt : (drop_m ? drop_t : pc_reg + 32'd4);
            end
        end
        #1;
        check_eq("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        check_eq("wpc", {31'h0, wpc}, {31'h0, e_wpc});
        if (e_wpc || !rst_n) check_eq("npc", npc, e_npc);
        if (e_req) check_eq("imem_addr", imem_addr, pc_reg);
        if (mdl_init) begin
            check_eq("id_valid", {31'h0, id_valid}, {31'h0, fq.size() > 0});
            check_eq("id_inst", id_inst, disp_inst);
            check_eq("id_pc4", id_pc4, disp_pc4);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            fq.delete();
            drop_m    = 1'b0;
            drop_t    = 32'h0;
            disp_inst = Nop;
            disp_pc4  = 32'h0;
            mdl_init  = 1'b1;
        end else begin
            if (fq.size() > 0 && !st) void'(fq.pop_front());
            if (!holding && imem_ack && !b && !drop_m) begin
                e.inst = imem_rdata;
                e.pc4  = pc_reg + 32'd4;
                fq.push_back(e);
            end
            if (!holding && imem_ack) drop_m = 1'b0;
            if (!holding && !imem_ack && b) begin
                drop_m = 1'b1;
                drop_t = bt;
            end
            if (b) begin
                fq.delete();
                disp_inst = Nop;
            end else if (fq.size() > 0) begin
                disp_inst = fq[0].inst;
                disp_pc4  = fq[0].pc4;
            end
        end
        if (e_wpc) pc_reg = e_npc;
    endtask

    initial begin
        // Reset, then back-to-back fetches from 0.
        cycle(0, 0, 0, 0, 0);
        repeat (4) cycle(1, 1, 0, 0, 0);
        // Slow memory: three wait cycles.
        repeat (3) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        // Decode stall fills the skid, then release.
        repeat (4) cycle(1, 1, 0, 0, 1);
        repeat (3) cycle(1, 1, 0, 0, 0);
        // Redirect while a fetch is outstanding.
        cycle(1, 0, 1, 32'h100, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (2) cycle(1, 1, 0, 0, 0);
        // Redirect with ack; repeated redirects while dropping.
        cycle(1, 1, 1, 32'h200, 0);
        cycle(1, 0, 1, 32'h300, 0);
        cycle(1, 0, 1, 32'h400, 0);
        repeat (2) cycle(1, 1, 0, 0, 0);
        // Redirect while holding a full skid.
        repeat (3) cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 1, 32'h500, 1);
        cycle(1, 1, 0, 0, 0);
        // Reset mid-fetch, and reset with the skid full.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        repeat (3) cycle(1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        // Sequential PC wrap at the top of the address space.
        pc_reg = 32'hFFFF_FFFC;
        repeat (3) cycle(1, 1, 0, 0, 0);
        // Randomized traffic with varying pressure.
        for (int i = 0; i < 4000; i++) begin
            int unsigned ack_pct;
            int unsigned stall_pct;
            ack_pct   = (i < 2000) ? 70 : 35;
            stall_pct = (i < 1000) ? 20 : 50;
            cycle(($urandom_range(99) >= 1),
                  ($urandom_range(99) < ack_pct),
                  ($urandom_range(99) < 8),
                  {$urandom_range(32'h0000_FFFF), 2'b00} ^ {$urandom_range(3), 30'h0},
                  ($urandom_range(99) < stall_pct));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
